// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared processor constants: opcodes, ALU ops, decoded-field struct and the
// stall controller state encoding. Also used by the bypass unit.
package hazard_stall_ctrl_pkg;

  localparam logic [4:0] OP_RTYPE = 5'b00000;
  localparam logic [4:0] OP_BNE   = 5'b00010;
  localparam logic [4:0] OP_JR    = 5'b00100;
  localparam logic [4:0] OP_BLT   = 5'b00110;
  localparam logic [4:0] OP_SW    = 5'b00111;
  localparam logic [4:0] OP_LW    = 5'b01000;
  localparam logic [4:0] OP_SETX  = 5'b10101;
  localparam logic [4:0] OP_BEX   = 5'b10110;

  localparam logic [4:0] ALU_MUL = 5'b00110;
  localparam logic [4:0] ALU_DIV = 5'b00111;

  localparam logic [4:0] REG_STATUS = 5'd30;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_LD_STALL = 2'd1,
    ST_MD_BUSY  = 2'd2
  } state_t;

  typedef struct packed {
    logic [4:0] opcode;
    logic [4:0] rd;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] alu_op;
  } ir_fields_t;

  // Returns {uses_b, src_b}: the second register an instruction reads, if any.
  function automatic logic [5:0] src_b_of(input ir_fields_t f);
    logic [5:0] r;
    r = 6'd0;
    case (f.opcode)
      OP_RTYPE:                      r = {1'b1, f.rt};
      OP_SW, OP_BNE, OP_BLT, OP_JR:  r = {1'b1, f.rd};
      OP_BEX:                        r = {1'b1, REG_STATUS};
      OP_SETX:                       r = 6'd0;
      default:                       r = 6'd0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/hazard_stall_ctrl_ir_fields.sv
// Splits one instruction word into its register/opcode fields and reports
// which register, if any, it reads as source B.
module ir_fields
  import hazard_stall_ctrl_pkg::*;
(
  input  logic [31:0] i_ir,
  output ir_fields_t  o_fields,
  output logic        o_uses_b,
  output logic [4:0]  o_src_b
);

  logic [5:0] w_src_b;
  logic       w_unused;

  assign o_fields.opcode = i_ir[31:27];
  assign o_fields.rd     = i_ir[26:22];
  assign o_fields.rs     = i_ir[21:17];
  assign o_fields.rt     = i_ir[16:12];
  assign o_fields.alu_op = i_ir[6:2];

  assign w_src_b  = src_b_of(o_fields);
  assign o_uses_b = w_src_b[5];
  assign o_src_b  = w_src_b[4:0];

  assign w_unused = ^{i_ir[11:7], i_ir[1:0]};

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Pipeline hazard/stall controller: load-use bubble, multdiv freeze and
// branch flush, with a saturating stall-cycle counter.
module hazard_stall_ctrl
  import hazard_stall_ctrl_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] fd_ir,
  input  logic [31:0] dx_ir,
  input  logic        branch_taken,
  input  logic        md_ready,
  output logic        pc_en,
  output logic        fd_en,
  output logic        dx_en,
  output logic        fd_nop,
  output logic        dx_nop,
  output logic        xm_nop,
  output logic        md_start,
  output logic        md_is_div,
  output logic [31:0] stall_count,
  output logic [1:0]  o_dbg_state
);

  ir_fields_t w_fd;
  ir_fields_t w_dx;
  logic       w_fd_uses_b;
  logic [4:0] w_fd_src_b;
  logic       w_dx_uses_b;
  logic [4:0] w_dx_src_b;
  logic       w_load_use;
  logic       w_md_op;
  logic       w_unused;
  state_t     r_state;
  state_t     w_next;
  logic [31:0] r_stall_count;

  ir_fields u_fd_fields (
    .i_ir     (fd_ir),
    .o_fields (w_fd),
    .o_uses_b (w_fd_uses_b),
    .o_src_b  (w_fd_src_b)
  );

  ir_fields u_dx_fields (
    .i_ir     (dx_ir),
    .o_fields (w_dx),
    .o_uses_b (w_dx_uses_b),
    .o_src_b  (w_dx_src_b)
  );

  assign w_unused = ^{w_dx.rs, w_dx.rt, w_dx_uses_b, w_dx_src_b, w_fd.rd, w_fd.rt, w_fd.alu_op};

  // A sw storing the loaded register gets it from the W->M bypass, not a stall.
  assign w_load_use = (w_dx.opcode == OP_LW) && (w_dx.rd != 5'd0) &&
                      ((w_fd.rs == w_dx.rd) ||
                       (w_fd_uses_b && (w_fd_src_b == w_dx.rd) && (w_fd.opcode != OP_SW)));

  assign w_md_op = (w_dx.opcode == OP_RTYPE) &&
                   ((w_dx.alu_op == ALU_MUL) || (w_dx.alu_op == ALU_DIV));

  always_comb begin
    pc_en     = 1'b1;
    fd_en     = 1'b1;
    dx_en     = 1'b1;
    fd_nop    = 1'b0;
    dx_nop    = 1'b0;
    xm_nop    = 1'b0;
    md_start  = 1'b0;
    md_is_div = 1'b0;
    w_next    = r_state;
    if (reset) begin
      fd_nop = 1'b1;
      dx_nop = 1'b1;
      xm_nop = 1'b1;
      w_next = ST_RUN;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (branch_taken) begin
            fd_nop = 1'b1;
            dx_nop = 1'b1;
          end else if (w_load_use) begin
            pc_en  = 1'b0;
            fd_en  = 1'b0;
            dx_nop = 1'b1;
            w_next = ST_LD_STALL;
          end else if (w_md_op) begin
            md_start  = 1'b1;
            md_is_div = w_dx.alu_op[0];
            pc_en     = 1'b0;
            fd_en     = 1'b0;
            dx_en     = 1'b0;
            xm_nop    = 1'b1;
            w_next    = ST_MD_BUSY;
          end
        end
        ST_LD_STALL: w_next = ST_RUN;
        ST_MD_BUSY: begin
          if (md_ready) begin
            w_next = ST_RUN;
          end else begin
            pc_en  = 1'b0;
            fd_en  = 1'b0;
            dx_en  = 1'b0;
            xm_nop = 1'b1;
          end
        end
        default: w_next = ST_RUN;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state       <= ST_RUN;
      r_stall_count <= 32'd0;
    end else begin
      r_state <= w_next;
      if (!pc_en && (r_stall_count != 32'hFFFF_FFFF))
        r_stall_count <= r_stall_count + 32'd1;
    end
  end

  assign stall_count = r_stall_count;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl: load-use, branch flush, multdiv
// freeze, stray md_ready and asynchronous reset during a multdiv wait.
module tb_hazard_stall_ctrl;
  import hazard_stall_ctrl_pkg::*;

  logic        clock;
  logic        reset;
  logic [31:0] fd_ir;
  logic [31:0] dx_ir;
  logic        branch_taken;
  logic        md_ready;
  logic        pc_en, fd_en, dx_en;
  logic        fd_nop, dx_nop, xm_nop;
  logic        md_start, md_is_div;
  logic [31:0] stall_count;
  logic [1:0]  o_dbg_state;
  logic [6:0]  w_outs;

  int n_vec;
  int n_err;
  logic [31:0] exp_stalls;

  // {pc_en, fd_en, dx_en, fd_nop, dx_nop, xm_nop, md_start}
  localparam logic [6:0] OUT_DEF    = 7'b1110000;
  localparam logic [6:0] OUT_RESET  = 7'b1111110;
  localparam logic [6:0] OUT_LD     = 7'b0010100;
  localparam logic [6:0] OUT_BRANCH = 7'b1111100;
  localparam logic [6:0] OUT_MD_GO  = 7'b0000011;
  localparam logic [6:0] OUT_MD_WT  = 7'b0000010;

  hazard_stall_ctrl dut (
    .clock        (clock),
    .reset        (reset),
    .fd_ir        (fd_ir),
    .dx_ir        (dx_ir),
    .branch_taken (branch_taken),
    .md_ready     (md_ready),
    .pc_en        (pc_en),
    .fd_en        (fd_en),
    .dx_en        (dx_en),
    .fd_nop       (fd_nop),
    .dx_nop       (dx_nop),
    .xm_nop       (xm_nop),
    .md_start     (md_start),
    .md_is_div    (md_is_div),
    .stall_count  (stall_count),
    .o_dbg_state  (o_dbg_state)
  );

  assign w_outs = {pc_en, fd_en, dx_en, fd_nop, dx_nop, xm_nop, md_start};

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, summary not yet printed");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] enc_r(input logic [4:0] rd, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [4:0] alu);
    return {5'b00000, rd, rs, rt, 5'b00000, alu, 2'b00};
  endfunction

  function automatic logic [31:0] enc_i(input logic [4:0] op, input logic [4:0] rd,
                                        input logic [4:0] rs, input logic [16:0] imm);
    return {op, rd, rs, imm};
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; fd_ir = '0; dx_ir = '0; branch_taken = 1'b0; md_ready = 1'b0;
    #2;
    n_vec++;
    if (w_outs !== OUT_RESET) begin
      n_err++; $display("FAIL reset_outs: got %b expected %b", w_outs, OUT_RESET);
    end
    n_vec++;
    if (stall_count !== 32'd0) begin
      n_err++; $display("FAIL reset_count: got %0d expected 0", stall_count);
    end
    n_vec++;
    if (o_dbg_state !== ST_RUN) begin
      n_err++; $display("FAIL reset_state: got %0d expected %0d", o_dbg_state, ST_RUN);
    end
    step();
    reset = 1'b0;
    exp_stalls = 32'd0;
    @(negedge clock);
    n_vec++;
    if (w_outs !== OUT_DEF) begin
      n_err++; $display("FAIL idle_outs: got %b expected %b", w_outs, OUT_DEF);
    end
    step();
  endtask

  task automatic test_load_use();
    logic [31:0] dx_tab [11];
    logic [31:0] fd_tab [11];
    logic        st_tab [11];
    dx_tab[0]  = enc_i(OP_LW, 5, 2, 0);   fd_tab[0]  = enc_r(6, 5, 7, 0);        st_tab[0]  = 1;
    dx_tab[1]  = enc_i(OP_LW, 5, 2, 0);   fd_tab[1]  = enc_r(6, 7, 5, 0);        st_tab[1]  = 1;
    dx_tab[2]  = enc_i(OP_LW, 5, 2, 0);   fd_tab[2]  = enc_i(OP_SW, 5, 2, 0);    st_tab[2]  = 0;
    dx_tab[3]  = enc_i(OP_LW, 5, 2, 0);   fd_tab[3]  = enc_i(OP_SW, 9, 5, 0);    st_tab[3]  = 1;
    dx_tab[4]  = enc_i(OP_LW, 5, 2, 0);   fd_tab[4]  = enc_i(OP_BNE, 5, 3, 4);   st_tab[4]  = 1;
    dx_tab[5]  = enc_i(OP_LW, 5, 2, 0);   fd_tab[5]  = enc_i(5'b00101, 5, 1, 3); st_tab[5]  = 0;
    dx_tab[6]  = enc_i(OP_LW, 5, 2, 0);   fd_tab[6]  = enc_i(OP_JR, 5, 0, 0);    st_tab[6]  = 1;
    dx_tab[7]  = enc_i(OP_LW, 0, 2, 0);   fd_tab[7]  = enc_r(6, 0, 0, 0);        st_tab[7]  = 0;
    dx_tab[8]  = enc_i(OP_LW, 30, 0, 0);  fd_tab[8]  = enc_i(OP_BEX, 0, 0, 100); st_tab[8]  = 1;
    dx_tab[9]  = enc_i(OP_LW, 5, 2, 0);   fd_tab[9]  = enc_r(5, 1, 2, 0);        st_tab[9]  = 0;
    dx_tab[10] = enc_i(5'b00101, 5, 0, 1); fd_tab[10] = enc_r(6, 5, 7, 0);       st_tab[10] = 0;
    for (int i = 0; i < 11; i++) begin
      dx_ir = dx_tab[i]; fd_ir = fd_tab[i];
      @(negedge clock);
      n_vec++;
      if (w_outs !== (st_tab[i] ? OUT_LD : OUT_DEF)) begin
        n_err++;
        $display("FAIL load_use[%0d]: got %b expected %b", i, w_outs, st_tab[i] ? OUT_LD : OUT_DEF);
      end
      step();
      if (st_tab[i]) begin
        exp_stalls++;
        n_vec++;
        if (o_dbg_state !== ST_LD_STALL) begin
          n_err++; $display("FAIL ld_state[%0d]: got %0d expected %0d", i, o_dbg_state, ST_LD_STALL);
        end
        @(negedge clock);
        n_vec++;
        if (w_outs !== OUT_DEF) begin
          n_err++; $display("FAIL ld_bubble_outs[%0d]: got %b expected %b", i, w_outs, OUT_DEF);
        end
        n_vec++;
        if (stall_count !== exp_stalls) begin
          n_err++; $display("FAIL ld_count[%0d]: got %0d expected %0d", i, stall_count, exp_stalls);
        end
        step();
        n_vec++;
        if (o_dbg_state !== ST_RUN) begin
          n_err++; $display("FAIL ld_return[%0d]: got %0d expected %0d", i, o_dbg_state, ST_RUN);
        end
      end
      dx_ir = '0; fd_ir = '0;
    end
  endtask

  task automatic test_branch();
    dx_ir = enc_i(OP_LW, 5, 2, 0); fd_ir = enc_r(6, 5, 7, 0); branch_taken = 1'b1;
    @(negedge clock);
    n_vec++;
    if (w_outs !== OUT_BRANCH) begin
      n_err++; $display("FAIL branch_over_load: got %b expected %b", w_outs, OUT_BRANCH);
    end
    step();
    n_vec++;
    if (o_dbg_state !== ST_RUN || stall_count !== exp_stalls) begin
      n_err++; $display("FAIL branch_no_ld: state %0d count %0d expected %0d count %0d",
                        o_dbg_state, stall_count, ST_RUN, exp_stalls);
    end
    dx_ir = enc_r(3, 1, 2, ALU_MUL); fd_ir = '0;
    @(negedge clock);
    n_vec++;
    if (w_outs !== OUT_BRANCH) begin
      n_err++; $display("FAIL branch_over_md: got %b expected %b", w_outs, OUT_BRANCH);
    end
    step();
    n_vec++;
    if (o_dbg_state !== ST_RUN) begin
      n_err++; $display("FAIL branch_no_md: got %0d expected %0d", o_dbg_state, ST_RUN);
    end
    branch_taken = 1'b0; dx_ir = '0;
  endtask

  task automatic test_multdiv(input logic is_div, input int wait_cycles);
    dx_ir = enc_r(3, 1, 2, is_div ? ALU_DIV : ALU_MUL); fd_ir = enc_r(4, 3, 3, 0); md_ready = 1'b0;
    @(negedge clock);
    n_vec++;
    if (w_outs !== OUT_MD_GO || md_is_div !== is_div) begin
      n_err++; $display("FAIL md_start: got %b div %b expected %b div %b", w_outs, md_is_div, OUT_MD_GO, is_div);
    end
    step();
    exp_stalls++;
    for (int c = 1; c < wait_cycles; c++) begin
      @(negedge clock);
      n_vec++;
      if (w_outs !== OUT_MD_WT || o_dbg_state !== ST_MD_BUSY) begin
        n_err++; $display("FAIL md_wait[%0d]: got %b state %0d expected %b state %0d",
                          c, w_outs, o_dbg_state, OUT_MD_WT, ST_MD_BUSY);
      end
      step();
      exp_stalls++;
    end
    md_ready = 1'b1;
    @(negedge clock);
    n_vec++;
    if (w_outs !== OUT_DEF) begin
      n_err++; $display("FAIL md_release: got %b expected %b", w_outs, OUT_DEF);
    end
    step();
    md_ready = 1'b0; dx_ir = '0; fd_ir = '0;
    n_vec++;
    if (o_dbg_state !== ST_RUN || stall_count !== exp_stalls) begin
      n_err++; $display("FAIL md_done: state %0d count %0d expected state %0d count %0d",
                        o_dbg_state, stall_count, ST_RUN, exp_stalls);
    end
  endtask

  task automatic test_md_ready_ignored();
    md_ready = 1'b1;
    @(negedge clock);
    n_vec++;
    if (w_outs !== OUT_DEF) begin
      n_err++; $display("FAIL stray_ready_run: got %b expected %b", w_outs, OUT_DEF);
    end
    step();
    md_ready = 1'b0;
    dx_ir = enc_i(OP_LW, 5, 2, 0); fd_ir = enc_r(6, 5, 7, 0);
    step();
    exp_stalls++;
    md_ready = 1'b1;
    @(negedge clock);
    n_vec++;
    if (w_outs !== OUT_DEF || o_dbg_state !== ST_LD_STALL) begin
      n_err++; $display("FAIL stray_ready_ld: got %b state %0d expected %b state %0d",
                        w_outs, o_dbg_state, OUT_DEF, ST_LD_STALL);
    end
    step();
    md_ready = 1'b0; dx_ir = '0; fd_ir = '0;
    n_vec++;
    if (o_dbg_state !== ST_RUN || stall_count !== exp_stalls) begin
      n_err++; $display("FAIL stray_ready_after: state %0d count %0d expected state %0d count %0d",
                        o_dbg_state, stall_count, ST_RUN, exp_stalls);
    end
  endtask

  task automatic test_reset_mid_md();
    dx_ir = enc_r(3, 1, 2, ALU_MUL); md_ready = 1'b0;
    step(); step(); step();
    #2;
    reset = 1'b1;
    #1;
    exp_stalls = 32'd0;
    n_vec++;
    if (o_dbg_state !== ST_RUN || stall_count !== exp_stalls) begin
      n_err++; $display("FAIL async_reset: state %0d count %0d expected state %0d count 0",
                        o_dbg_state, stall_count, ST_RUN);
    end
    n_vec++;
    if (w_outs !== OUT_RESET) begin
      n_err++; $display("FAIL async_reset_outs: got %b expected %b", w_outs, OUT_RESET);
    end
    step();
    reset = 1'b0; dx_ir = '0; md_ready = 1'b1;
    @(negedge clock);
    n_vec++;
    if (w_outs !== OUT_DEF) begin
      n_err++; $display("FAIL post_reset_ready: got %b expected %b", w_outs, OUT_DEF);
    end
    step();
    md_ready = 1'b0;
    n_vec++;
    if (o_dbg_state !== ST_RUN || stall_count !== exp_stalls) begin
      n_err++; $display("FAIL post_reset_state: state %0d count %0d expected state %0d count 0",
                        o_dbg_state, stall_count, ST_RUN);
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    exp_stalls = 32'd0;
    test_reset();
    test_load_use();
    test_branch();
    test_multdiv(1'b0, 33);
    test_multdiv(1'b1, 3);
    test_md_ready_ignored();
    test_reset_mid_md();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
